setpoint_ramp_arbiter: RTL and testbench
========================================

# setpoint_ramp_arbiter

Shares the control-loop reference register between two requesters: the keypad validation path (port A) and the host/preset path (port B). Accepted requests are arbitrated round-robin and latched as a target. The published setpoint then moves toward that target in fixed signed steps, one step per prescaler tick, so the downstream controller never sees a step jump. The block sits between the scan-code validator/host interface and the regulator datapath.

## Interface
- W, 18, width of reference values (two's complement signed)
- STEP, 64, magnitude of one ramp step (unsigned, 1..2^(W-1)-1)
- TICK_DIV, 1000, clock cycles per ramp tick (≥2)
- MIN_REF, -131072, lower clamp bound (used only with SETPOINT_CLAMP_EN)
- MAX_REF, 131071, upper clamp bound (used only with SETPOINT_CLAMP_EN)

- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- a_valid  in  1  request A present; may stay high for many cycles
- a_ref  in  W  request A value, signed
- a_ready  out  1  request A can be accepted this cycle
- b_valid  in  1  request B present
- b_ref  in  W  request B value, signed
- b_ready  out  1  request B can be accepted this cycle
- grant_a  out  1  one-cycle pulse: A's value was latched
- grant_b  out  1  one-cycle pulse: B's value was latched
- setpoint  out  W  current published reference, signed, registered
- target  out  W  latched destination, signed, registered
- busy  out  1  high in LOAD and RAMP
- done  out  1  one-cycle pulse when setpoint reaches target

## Operation
- States: IDLE, LOAD, RAMP.
- a_ready = b_ready = (state != LOAD). This is combinational from state.
- Acceptance: a port is accepted at the edge where valid&ready is high for it.
- Tie (both valid and ready): the port not granted last wins. last_grant resets to B, so A wins the first tie. Only one port is accepted per edge; the loser keeps waiting.
- On acceptance: target ← incoming value (clamped if configured), grant_x = 1 for the next cycle, state → LOAD. This applies from IDLE and from RAMP (retarget). setpoint is untouched, so there is no jump.
- LOAD (exactly 1 cycle):
  - Prescaler cleared.
  - If setpoint == target: → IDLE, done pulses in the next cycle.
  - Otherwise: → RAMP.
- RAMP: prescaler counts 0..TICK_DIV-1. Tick occurs when count == TICK_DIV-1, then count wraps to 0. On each tick:
  - diff = target − setpoint, computed at W+1 bits signed so it never overflows.
  - If |diff| ≤ STEP: setpoint ← target, → IDLE, done pulses in the next cycle.
  - Otherwise: setpoint ← setpoint ± STEP, moving toward target.
  - setpoint never overshoots target and never wraps.
- An acceptance in RAMP takes priority over a tick in the same cycle: the tick is discarded and the FSM goes to LOAD.
- Repeated acceptance of an unchanged value is legal. It restarts the prescaler.
- An illegal state encoding goes to IDLE.

## Timing
- Reset values: setpoint 0, target 0, busy 0, done 0, grant_a 0, grant_b 0, a_ready 1, b_ready 1, state IDLE, prescaler 0, last_grant B.
- Acceptance at edge k:
  - grant_x is high and state is LOAD during cycle k+1.
  - The first setpoint update occurs at edge k+1+TICK_DIV.
- A ramp covering distance D completes at edge k+1+ceil(D/STEP)·TICK_DIV.
- done is high in the cycle after setpoint becomes equal to target. busy is low in that same cycle.
- Assertion of reset mid-ramp immediately forces the reset values. Ramping resumes only on a new request.

## Configuration
- SETPOINT_CLAMP_EN defined:
  - Incoming values are saturated to [MIN_REF, MAX_REF] before being written to target.
  - MIN_REF ≤ MAX_REF is required.
- SETPOINT_CLAMP_EN undefined:
  - target is written with the raw request value.
  - MIN_REF and MAX_REF are ignored.

## Test plan
- Use W=18, STEP=64, TICK_DIV=4 unless noted.
- Ramp down: from reset, a_valid=1 for 1 cycle with a_ref=18'h3FF00 (−256). Expect grant_a 1 cycle later. setpoint goes −64, −128, −192, −256 at 4-cycle intervals, first at +5 cycles. Then done pulses once and busy falls.
- Partial last step: b_ref=100 from setpoint 0. Expect setpoint 64, then 100. done follows the second step.
- Tie and fairness: a_valid and b_valid both high, holding a_ref=100 and b_ref=200.
  - Expect grant_a first, LOAD, then grant_b at the next ready cycle.
  - Final setpoint is 200.
  - A third simultaneous request is granted to A.
- Retarget mid-ramp: ramp toward 512, and at setpoint 128 request −64. Expect no jump: setpoint goes 64, 0, −64, then done.
- Reset mid-ramp: assert reset while setpoint=192. Expect setpoint 0, target 0, busy 0, and readies 1 asynchronously.
- Clamp with SETPOINT_CLAMP_EN, MAX_REF=1000: request 2000. Expect target=1000 and the ramp ending at 1000. Without the macro, expect target=2000.

Source files
------------

// File: rtl/setpoint_ramp_arbiter.sv
// setpoint_ramp_arbiter
//
// Shares the control-loop reference register between two requesters.
// Port A is the keypad validation path and port B is the host/preset path.
// Accepted requests are arbitrated round-robin and latched into `target`.
// The published `setpoint` then walks toward `target` in signed steps of STEP,
// one step per prescaler tick of TICK_DIV clocks, so it never jumps.
//
// Optional feature: define SETPOINT_CLAMP_EN to saturate incoming requests to
// [MIN_REF, MAX_REF] before they are written to target. Without the macro the
// raw request value is latched, and MIN_REF/MAX_REF are ignored.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   a_valid/a_ref    request A (signed W bits), a_ready = can accept this cycle
//   b_valid/b_ref    request B (signed W bits), b_ready = can accept this cycle
//   grant_a/grant_b  one-cycle pulse after the corresponding value was latched
//   setpoint         published reference (registered, signed)
//   target           latched destination (registered, signed)
//   busy             high while loading or ramping
//   done             one-cycle pulse after setpoint reaches target
module setpoint_ramp_arbiter #(
  parameter int W        = 18,
  parameter int STEP     = 64,
  parameter int TICK_DIV = 1000,
  parameter int MIN_REF  = -131072,
  parameter int MAX_REF  = 131071
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  input  logic [W-1:0] a_ref,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_ref,
  output logic         b_ready,
  output logic         grant_a,
  output logic         grant_b,
  output logic [W-1:0] setpoint,
  output logic [W-1:0] target,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } state_t;

  localparam int                PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic signed [W:0] STEP_X    = (W+1)'(STEP);
  localparam logic [W-1:0]      STEP_W    = W'(STEP);

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [W-1:0]  setpoint_d, target_d;
  logic          grant_a_d, grant_b_d, done_d;
  logic          last_b, last_b_d;       // 1: B was granted last
  logic          acc_a, acc_b;
  logic [W-1:0]  req_ref, req_val;
  logic signed [W:0] diff, diff_abs;

  assign a_ready = (state != LOAD);
  assign b_ready = (state != LOAD);
  assign busy    = (state == LOAD) || (state == RAMP);

  // On a tie the port that was not granted last wins.
  assign acc_a   = a_valid && a_ready && (!b_valid || last_b);
  assign acc_b   = b_valid && b_ready && !acc_a;
  assign req_ref = acc_a ? a_ref : b_ref;

`ifdef SETPOINT_CLAMP_EN
  localparam logic signed [W-1:0] MIN_W = W'(MIN_REF);
  localparam logic signed [W-1:0] MAX_W = W'(MAX_REF);

  always_comb begin
    req_val = req_ref;
    if ($signed(req_ref) < MIN_W)
      req_val = MIN_W;
    else if ($signed(req_ref) > MAX_W)
      req_val = MAX_W;
  end
`else
  assign req_val = req_ref;
`endif

  // One extra bit so the distance between any two W-bit values fits.
  assign diff     = $signed({target[W-1], target}) - $signed({setpoint[W-1], setpoint});
  assign diff_abs = diff[W] ? -diff : diff;

  always_comb begin
    state_d    = state;
    presc_d    = presc;
    setpoint_d = setpoint;
    target_d   = target;
    grant_a_d  = 1'b0;
    grant_b_d  = 1'b0;
    done_d     = 1'b0;
    last_b_d   = last_b;

    case (state)
      IDLE, RAMP: begin
        if (acc_a || acc_b) begin
          // Acceptance outranks a coincident tick; the tick is dropped.
          target_d  = req_val;
          grant_a_d = acc_a;
          grant_b_d = acc_b;
          last_b_d  = acc_b;
          presc_d   = '0;
          state_d   = LOAD;
        end else if (state == RAMP) begin
          if (presc == TICK_LAST) begin
            presc_d = '0;
            if (diff_abs <= STEP_X) begin
              setpoint_d = target;
              done_d     = 1'b1;
              state_d    = IDLE;
            end else if (diff[W]) begin
              setpoint_d = setpoint - STEP_W;
            end else begin
              setpoint_d = setpoint + STEP_W;
            end
          end else begin
            presc_d = presc + 1'b1;
          end
        end
      end
      LOAD: begin
        presc_d = '0;
        if (setpoint == target) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RAMP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      setpoint <= '0;
      target   <= '0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      done     <= 1'b0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_d;
      presc    <= presc_d;
      setpoint <= setpoint_d;
      target   <= target_d;
      grant_a  <= grant_a_d;
      grant_b  <= grant_b_d;
      done     <= done_d;
      last_b   <= last_b_d;
    end
  end

endmodule

// File: tb/tb_setpoint_ramp_arbiter.sv
// Self-checking bench for setpoint_ramp_arbiter: directed scenarios with
// hand-computed expectations plus randomized traffic, all compared every
// cycle against an event/time-based behavioural model.
module tb_setpoint_ramp_arbiter;

  localparam int W        = 18;
  localparam int STEP     = 64;
  localparam int TICK_DIV = 4;
  localparam int MIN_REF  = -131072;
  localparam int MAX_REF  = 1000;
`ifdef SETPOINT_CLAMP_EN
  localparam int CLAMP_EXP = 1000;
`else
  localparam int CLAMP_EXP = 2000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic signed [W-1:0] a_ref = '0, b_ref = '0;
  logic a_ready, b_ready, grant_a, grant_b, busy, done;
  logic signed [W-1:0] setpoint, target;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  setpoint_ramp_arbiter #(
    .W(W), .STEP(STEP), .TICK_DIV(TICK_DIV), .MIN_REF(MIN_REF), .MAX_REF(MAX_REF)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ref(a_ref), .a_ready(a_ready),
    .b_valid(b_valid), .b_ref(b_ref), .b_ready(b_ready),
    .grant_a(grant_a), .grant_b(grant_b),
    .setpoint(setpoint), .target(target),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampf(int v);
`ifdef SETPOINT_CLAMP_EN
    if (v < MIN_REF) return MIN_REF;
    if (v > MAX_REF) return MAX_REF;
`endif
    return v;
  endfunction

  // Behavioural model: tracks the edge index and the absolute edge at which
  // the next ramp step is due, instead of a prescaler count.
  int m_sp, m_tgt, m_edge, m_next;
  bit m_busy, m_load, m_last_b, m_ga, m_gb, m_done;

  always @(posedge clk or posedge reset) begin : model
    int v, d, e;
    bit pa, pb;
    if (reset) begin
      m_sp <= 0; m_tgt <= 0; m_edge <= 0; m_next <= 0;
      m_busy <= 0; m_load <= 0; m_last_b <= 1;
      m_ga <= 0; m_gb <= 0; m_done <= 0;
    end else begin
      e = m_edge + 1;
      m_edge <= e;
      m_ga <= 0; m_gb <= 0; m_done <= 0;
      pa = a_valid && !m_load && (!b_valid || m_last_b);
      pb = b_valid && !m_load && !pa;
      if (pa || pb) begin
        v = clampf(pa ? int'(a_ref) : int'(b_ref));
        m_tgt <= v; m_ga <= pa; m_gb <= pb; m_last_b <= pb;
        m_load <= 1; m_busy <= 1;
        m_next <= e + 1 + TICK_DIV;
      end else if (m_load) begin
        m_load <= 0;
        if (m_sp == m_tgt) begin
          m_busy <= 0; m_done <= 1;
        end
      end else if (m_busy && e == m_next) begin
        d = m_tgt - m_sp;
        if (d <= STEP && d >= -STEP) begin
          m_sp <= m_tgt; m_busy <= 0; m_done <= 1;
        end else begin
          m_sp <= (d > 0) ? m_sp + STEP : m_sp - STEP;
          m_next <= m_next + TICK_DIV;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("setpoint", setpoint, m_sp);
      chk("target", target, m_tgt);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("grant_a", grant_a, m_ga);
      chk("grant_b", grant_b, m_gb);
      chk("a_ready", a_ready, !m_load);
      chk("b_ready", b_ready, !m_load);
    end
  end

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, seen, 1);
  endtask

  task automatic wait_sp(input int val, input int limit, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (setpoint == W'(val)) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, seen, 1);
  endtask

  function automatic logic signed [W-1:0] pick_ref();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return W'(m_tgt);
      1: return W'(m_sp);
      2: return W'(-131072);
      3: return W'(131071);
      7: return W'($urandom);
      default: return W'(int'($urandom_range(0, 1200)) - 600);
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int seq[$];
    int prev;
    int exp3[3];
    int got;

    // Reset values
    wait_neg(2);
    chk("rst_setpoint", setpoint, 0);
    chk("rst_target", target, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant_a", grant_a, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    reset = 1'b0;
    chk_en = 1'b1;

    // Ramp down to -256
    a_valid = 1'b1; a_ref = W'(-256);
    @(negedge clk);
    chk("down_grant_a", grant_a, 1);
    chk("down_a_ready", a_ready, 0);
    chk("down_target", target, -256);
    a_valid = 1'b0;
    wait_neg(4);  chk("down_sp_hold", setpoint, 0);
    wait_neg(1);  chk("down_sp1", setpoint, -64);
    wait_neg(4);  chk("down_sp2", setpoint, -128);
    wait_neg(4);  chk("down_sp3", setpoint, -192);
    wait_neg(3);  chk("down_sp3_hold", setpoint, -192);
                  chk("down_done_early", done, 0);
    wait_neg(1);  chk("down_sp4", setpoint, -256);
                  chk("down_done", done, 1);
                  chk("down_busy", busy, 0);
    wait_neg(1);  chk("down_done_once", done, 0);

    // Partial last step
    do_reset();
    b_valid = 1'b1; b_ref = W'(100);
    @(negedge clk);
    chk("part_grant_b", grant_b, 1);
    b_valid = 1'b0;
    wait_neg(5);  chk("part_sp1", setpoint, 64);
                  chk("part_done_early", done, 0);
    wait_neg(4);  chk("part_sp2", setpoint, 100);
                  chk("part_done", done, 1);

    // Tie and fairness
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_ref = W'(100); b_ref = W'(200);
    @(negedge clk);
    chk("tie1_grant_a", grant_a, 1);
    chk("tie1_grant_b", grant_b, 0);
    @(negedge clk);
    chk("tie_load_gap", grant_b, 0);
    chk("tie_ready_back", a_ready, 1);
    @(negedge clk);
    chk("tie2_grant_b", grant_b, 1);
    chk("tie2_grant_a", grant_a, 0);
    chk("tie2_target", target, 200);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_done(200, "tie_done");
    chk("tie_final_sp", setpoint, 200);
    a_valid = 1'b1; b_valid = 1'b1; a_ref = W'(300); b_ref = W'(-300);
    @(negedge clk);
    chk("tie3_grant_a", grant_a, 1);
    chk("tie3_grant_b", grant_b, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_done(200, "tie3_done");

    // Retarget mid-ramp
    do_reset();
    a_valid = 1'b1; a_ref = W'(512);
    @(negedge clk);
    a_valid = 1'b0;
    wait_sp(128, 100, "retgt_reach_128");
    a_valid = 1'b1; a_ref = W'(-64);
    @(negedge clk);
    a_valid = 1'b0;
    chk("retgt_grant", grant_a, 1);
    chk("retgt_no_jump", setpoint, 128);
    prev = 128;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (setpoint != W'(prev)) begin
        seq.push_back(int'(setpoint));
        prev = int'(setpoint);
      end
      if (done) break;
    end
    exp3 = '{64, 0, -64};
    chk("retgt_steps", seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < seq.size()) ? seq[i] : 99999;
      chk("retgt_seq", got, exp3[i]);
    end

    // Reset mid-ramp
    do_reset();
    a_valid = 1'b1; a_ref = W'(256);
    @(negedge clk);
    a_valid = 1'b0;
    wait_sp(192, 100, "mid_reach_192");
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sp", setpoint, 0);
    chk("mid_rst_target", target, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_a_ready", a_ready, 1);
    chk("mid_rst_b_ready", b_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(20);
    chk("mid_stays_sp", setpoint, 0);
    chk("mid_stays_busy", busy, 0);

    // Clamp
    do_reset();
    b_valid = 1'b1; b_ref = W'(2000);
    @(negedge clk);
    b_valid = 1'b0;
    chk("clamp_target", target, CLAMP_EXP);
    wait_done(400, "clamp_done");
    chk("clamp_final_sp", setpoint, CLAMP_EXP);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        a_valid = ($urandom_range(0, 4) == 0);
        a_ref = pick_ref();
      end
      if ($urandom_range(0, 7) == 0) begin
        b_valid = ($urandom_range(0, 4) == 0);
        b_ref = pick_ref();
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    wait_neg(4);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
